hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the fixed EX/MEM/WB stall/forward logic. Tracks in-flight
//  register writes as a shift-register scoreboard {valid,A3,tnew} over NSTAGE post-ID stages.
//  Emits the ID stall, per-read-port forward selects for ID, and owns the MULDIV busy timer.
//  Sits beside the decode controller: consumes its A3/RegWrite/tnew/tuse, drives pipeline enables.
// PARAMETERS
//  NSTAGE    3   post-ID stages tracked (stage0=EX ... NSTAGE-1=WB)
//  NREAD     2   ID register read ports (rs, rt, ...)
//  TW        2   width of tnew/tuse; all-ones tuse = "never used"
//  MULT_LAT  5   busy cycles for mult/multu
//  DIV_LAT   10  busy cycles for div/divu
// PORTS
//  clk          in   1             clock, rising edge
//  reset        in   1             synchronous, active-high
//  id_we        in   1             ID instr writes a GPR (RegWrite)
//  id_a3        in   5             ID destination register
//  id_tnew      in   TW            ID tnew as seen at stage0 (EX)
//  id_rd_addr   in   5*NREAD       packed read addresses, port r at [5r+4:5r]
//  id_tuse      in   TW*NREAD      packed tuse per read port
//  id_md_type   in   1             ID instr is a MULDIV-class op (mfhi..mtlo)
//  ex_md_start  in   1             EX is starting mult/div this cycle
//  ex_md_div    in   1             qualifies ex_md_start: 1=div/divu, 0=mult/multu
//  stall        out  1             freeze PC/IF-ID, bubble into EX
//  id_fwd_sel   out  SW*NREAD      SW=$clog2(NSTAGE+1); 0=regfile, k=stage k-1 result
//  md_busy      out  1             MULDIV timer non-zero
//  stall_cnt    out  32            stall-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all entries valid=0, a3=0, tnew=0; md counter=0; stall=0, fwd_sel=0, md_busy=0,
//    stall_cnt=0. Reset mid-operation discards in-flight entries and aborts the MULDIV timer.
//  - Scoreboard shift each cycle: entry[s] <= entry[s-1] with tnew decremented, saturating
//    at 0. entry[0] <= {id_we & ~stall & id_a3!=0, id_a3, id_tnew}; on stall entry[0] is a bubble.
//  - Match(r,s): entry[s].valid & entry[s].a3 == rd_addr[r] & rd_addr[r] != 0.
//  - Nearest match per port (lowest s) wins; older matches ignored (priority EX>MEM>WB).
//  - id_fwd_sel[r] = s+1 of nearest match, else 0. Combinational from registered state + inputs.
//  - Data stall: any r with nearest match and id_tuse[r] < entry[s].tnew.
//  - tuse all-ones never stalls (tnew max is all-ones minus 1 by contract).
//  - MULDIV timer: ex_md_start loads counter with DIV_LAT or MULT_LAT (takes effect next cycle);
//    decrements to 0; md_busy = counter!=0. A new start while busy reloads (cannot occur legally).
//  - MD stall: id_md_type & (ex_md_start | md_busy).
//  - stall = data stall | MD stall. Zero latency (same-cycle); scoreboard update is 1 cycle.
//  - Simultaneous start and last busy cycle: load wins, md_busy stays 1.
// CONFIGURATION
//  HAZARD_STATS_EN defined: stall_cnt increments on every cycle stall=1, wraps at 2^32-1 -> 0,
//  cleared only by reset. Undefined: counter not built, stall_cnt tied to 32'd0.
// STRUCTURE
//  Shared package/header hazard_pkg: FWD_REGFILE=0, TUSE_NEVER, MD_LAT defaults,
//  entry struct/field widths, fwd_sel width function.
//  One sub-module: hz_muldiv_timer (load/decrement counter, md_busy). Scoreboard and
//  compare logic stay in the top via generate loops over NSTAGE x NREAD.
// TESTING (defaults NSTAGE=3, NREAD=2)
//  1 lw $8 (tnew=2) then addu rs=$8 tuse=1 -> stall=1 one cycle, next cycle fwd_sel[0]=2, stall=0.
//  2 addu $9 (tnew=1), next beq rs=$9 tuse=0 -> stall 1 cycle; then fwd_sel[0]=2 (MEM), no stall.
//  3 EX and MEM both write $5, ID reads $5 in rt -> fwd_sel[1]=1 (EX wins); read $0 -> fwd_sel=0.
//  4 ex_md_start with ex_md_div=1, mflo in ID -> stall for 11 cycles (start + DIV_LAT),
//    md_busy falls after 10.
//  5 reset asserted with lw in EX and div busy -> next cycle md_busy=0, fwd_sel=0, stall=0.
//  6 HAZARD_STATS_EN: scenario 4 -> stall_cnt=11; without macro stall_cnt=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared hazard-unit types and constants: register address width, forward-select encoding,
// MULDIV latency defaults and the forward-select width helper.
// No logic; latency and backpressure are defined by the modules that import it.
package hazard_pkg;

   localparam int A_W          = 5;
   localparam int FWD_REGFILE  = 0;
   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;
   localparam int TW_DEF       = 2;

   // All-ones tuse means the operand is never read; tnew never reaches this value.
   localparam logic [TW_DEF-1:0] TUSE_NEVER = '1;

   typedef logic [A_W-1:0] reg_addr_t;

   // One code per tracked stage plus the regfile code.
   function automatic int fwd_sel_w(input int nstage);
      return $clog2(nstage + 1);
   endfunction

endpackage

// File: rtl/hz_muldiv_timer.sv
// MULDIV busy timer: loads DIV_LAT or MULT_LAT on start, counts down to zero.
// Latency: load visible the cycle after start; busy is a registered compare.
// Backpressure: none; a start while busy simply reloads.
module hz_muldiv_timer #(
   parameter int  MULT_LAT = 5,
   parameter int  DIV_LAT  = 10,
   localparam int MAX_LAT  = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT,
   localparam int CW       = $clog2(MAX_LAT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy
);

   logic [CW-1:0] cnt;

   // Load has priority so a start on the last busy cycle keeps busy high.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: shift-register write scoreboard, stall, per-port forward selects, MULDIV busy.
// Latency: stall/fwd_sel are same-cycle combinational; scoreboard advances one stage per cycle.
// Backpressure: stall freezes PC/IF-ID and bubbles EX; HAZARD_STATS_EN builds the stall counter.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int  NSTAGE   = 3,
   parameter int  NREAD    = 2,
   parameter int  TW       = TW_DEF,
   parameter int  MULT_LAT = MULT_LAT_DEF,
   parameter int  DIV_LAT  = DIV_LAT_DEF,
   localparam int SW       = fwd_sel_w(NSTAGE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_we,
   input  logic [A_W-1:0]        id_a3,
   input  logic [TW-1:0]         id_tnew,
   input  logic [A_W*NREAD-1:0]  id_rd_addr,
   input  logic [TW*NREAD-1:0]   id_tuse,
   input  logic                  id_md_type,
   input  logic                  ex_md_start,
   input  logic                  ex_md_div,
   output logic                  stall,
   output logic [SW*NREAD-1:0]   id_fwd_sel,
   output logic                  md_busy,
   output logic [31:0]           stall_cnt
);

   typedef struct packed {
      logic          valid;
      reg_addr_t     a3;
      logic [TW-1:0] tnew;
   } entry_t;

   entry_t            sb [NSTAGE];
   logic [NSTAGE-1:0] match [NREAD];
   logic [NREAD-1:0]  port_hz;
   logic              data_stall;
   logic              md_stall;

   // Stalled ID inserts a bubble; tnew counts down as the write moves toward WB.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < NSTAGE; s++) begin
            sb[s] <= '0;
         end
      end else begin
         sb[0].valid <= id_we & ~stall & (id_a3 != '0);
         sb[0].a3    <= id_a3;
         sb[0].tnew  <= id_tnew;
         for (int s = 1; s < NSTAGE; s++) begin
            sb[s].valid <= sb[s-1].valid;
            sb[s].a3    <= sb[s-1].a3;
            sb[s].tnew  <= (sb[s-1].tnew != '0) ? sb[s-1].tnew - 1'b1 : '0;
         end
      end
   end

   for (genvar r = 0; r < NREAD; r++) begin : g_port
      logic [A_W-1:0] rd;
      logic [TW-1:0]  tuse;
      logic [SW-1:0]  sel;
      logic           hz;

      assign rd   = id_rd_addr[A_W*r +: A_W];
      assign tuse = id_tuse[TW*r +: TW];

      for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
         assign match[r][s] = sb[s].valid && (sb[s].a3 == rd) && (rd != '0);
      end

      // Walk oldest to youngest so the nearest producer overwrites older ones.
      always_comb begin
         sel = SW'(FWD_REGFILE);
         hz  = 1'b0;
         for (int s = NSTAGE - 1; s >= 0; s--) begin
            if (match[r][s]) begin
               sel = SW'(s + 1);
               hz  = (tuse < sb[s].tnew);
            end
         end
      end

      assign id_fwd_sel[SW*r +: SW] = sel;
      assign port_hz[r]             = hz;
   end

   hz_muldiv_timer #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (ex_md_start),
      .is_div (ex_md_div),
      .busy   (md_busy)
   );

   assign data_stall = |port_hz;
   assign md_stall   = id_md_type & (ex_md_start | md_busy);
   assign stall      = data_stall | md_stall;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (stall) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations plus a random run
// checked every cycle against an in-flight-write list model.
module tb_hazard_scoreboard;

   localparam int NSTAGE = 3;
   localparam int NREAD  = 2;
   localparam int TW     = 2;
   localparam int SW     = 2;

   logic                clk = 1'b0;
   logic                reset;
   logic                id_we;
   logic [4:0]          id_a3;
   logic [TW-1:0]       id_tnew;
   logic [5*NREAD-1:0]  id_rd_addr;
   logic [TW*NREAD-1:0] id_tuse;
   logic                id_md_type;
   logic                ex_md_start;
   logic                ex_md_div;
   logic                stall;
   logic [SW*NREAD-1:0] id_fwd_sel;
   logic                md_busy;
   logic [31:0]         stall_cnt;

   hazard_scoreboard #(.NSTAGE(NSTAGE), .NREAD(NREAD), .TW(TW), .MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset(reset), .id_we(id_we), .id_a3(id_a3), .id_tnew(id_tnew),
      .id_rd_addr(id_rd_addr), .id_tuse(id_tuse), .id_md_type(id_md_type),
      .ex_md_start(ex_md_start), .ex_md_div(ex_md_div), .stall(stall),
      .id_fwd_sel(id_fwd_sel), .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Model: every accepted write is remembered with its issue cycle; its stage and
   // remaining tnew follow from the cycle distance alone.
   typedef struct {
      int a3;
      int tnew0;
      int issue;
   } wr_t;

   wr_t q[$];
   int  cyc      = 0;
   int  md_end   = 0;
   int  m_cnt    = 0;
   int  n_cmp    = 0;
   int  n_bad    = 0;
   bit  exp_stall;
   int  exp_sel [NREAD];
   bit  exp_busy;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input bit we, input int a3, input int tnew, input int rd0, input int rd1,
                        input int tu0, input int tu1, input bit mdt, input bit mds, input bit mdd);
      id_we       = we;
      id_a3       = 5'(a3);
      id_tnew     = TW'(tnew);
      id_rd_addr  = {5'(rd1), 5'(rd0)};
      id_tuse     = {TW'(tu1), TW'(tu0)};
      id_md_type  = mdt;
      ex_md_start = mds;
      ex_md_div   = mdd;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 3, 3, 0, 0, 0);
   endtask

   // Evaluate the model for the current inputs and compare every output.
   task automatic settle();
      int best, tn, st, rd, tu;
      @(negedge clk);
      exp_stall = 0;
      for (int r = 0; r < NREAD; r++) begin
         rd   = int'(id_rd_addr[5*r +: 5]);
         tu   = int'(id_tuse[TW*r +: TW]);
         best = NSTAGE;
         tn   = 0;
         foreach (q[i]) begin
            st = cyc - q[i].issue - 1;
            if (st >= 0 && st < NSTAGE && q[i].a3 == rd && rd != 0 && st < best) begin
               best = st;
               tn   = (q[i].tnew0 > st) ? q[i].tnew0 - st : 0;
            end
         end
         exp_sel[r] = (best < NSTAGE) ? best + 1 : 0;
         if (best < NSTAGE && tu < tn) exp_stall = 1;
      end
      exp_busy = (cyc < md_end);
      if (id_md_type && (ex_md_start || exp_busy)) exp_stall = 1;
      if (!reset) begin
         check("stall", int'(stall), int'(exp_stall));
         check("md_busy", int'(md_busy), int'(exp_busy));
         for (int r = 0; r < NREAD; r++)
            check($sformatf("fwd_sel[%0d]", r), int'(id_fwd_sel[SW*r +: SW]), exp_sel[r]);
`ifdef HAZARD_STATS_EN
         check("stall_cnt", int'(stall_cnt), m_cnt);
`else
         check("stall_cnt", int'(stall_cnt), 0);
`endif
      end
   endtask

   task automatic adv();
      @(posedge clk);
      if (reset) begin
         q.delete();
         md_end = 0;
         m_cnt  = 0;
      end else begin
         if (id_we && !exp_stall && id_a3 != 0)
            q.push_back('{a3: int'(id_a3), tnew0: int'(id_tnew), issue: cyc});
         if (ex_md_start) md_end = cyc + 1 + (ex_md_div ? 10 : 5);
         if (exp_stall) m_cnt++;
      end
      cyc++;
      while (q.size() > 0 && cyc - q[0].issue - 1 >= NSTAGE) void'(q.pop_front());
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      settle();
      adv();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      do_reset();

      // Reset state
      idle();
      settle();
      check("rst stall", int'(stall), 0);
      check("rst fwd_sel", int'(id_fwd_sel), 0);
      check("rst md_busy", int'(md_busy), 0);
      check("rst stall_cnt", int'(stall_cnt), 0);
      adv();

      // lw $8 tnew=2, then addu rs=$8 tuse=1
      drive(1, 8, 2, 0, 0, 3, 3, 0, 0, 0);
      settle(); adv();
      drive(1, 10, 1, 8, 0, 1, 3, 0, 0, 0);
      settle();
      check("s1 stall", int'(stall), 1);
      adv();
      settle();
      check("s1 stall after", int'(stall), 0);
      check("s1 fwd_sel0", int'(id_fwd_sel[1:0]), 2);
      adv();
      repeat (3) begin idle(); settle(); adv(); end

      // addu $9 tnew=1, then beq rs=$9 tuse=0
      drive(1, 9, 1, 0, 0, 3, 3, 0, 0, 0);
      settle(); adv();
      drive(0, 0, 0, 9, 0, 0, 3, 0, 0, 0);
      settle();
      check("s2 stall", int'(stall), 1);
      adv();
      settle();
      check("s2 stall after", int'(stall), 0);
      check("s2 fwd_sel0", int'(id_fwd_sel[1:0]), 2);
      adv();
      repeat (3) begin idle(); settle(); adv(); end

      // Two writers of $5 in flight; rt reads $5, rs reads $0
      drive(1, 5, 1, 0, 0, 3, 3, 0, 0, 0);
      settle(); adv();
      drive(1, 5, 1, 0, 0, 3, 3, 0, 0, 0);
      settle(); adv();
      drive(0, 0, 0, 0, 5, 3, 3, 0, 0, 0);
      settle();
      check("s3 fwd_sel1", int'(id_fwd_sel[3:2]), 1);
      check("s3 fwd_sel0", int'(id_fwd_sel[1:0]), 0);
      check("s3 stall", int'(stall), 0);
      adv();
      repeat (3) begin idle(); settle(); adv(); end

      // div start with mflo in ID: 11 stall cycles, busy for 10
      do_reset();
      drive(0, 0, 0, 0, 0, 3, 3, 1, 1, 1);
      settle();
      check("s4 stall c0", int'(stall), 1);
      check("s4 busy c0", int'(md_busy), 0);
      adv();
      for (int i = 1; i <= 11; i++) begin
         drive(0, 0, 0, 0, 0, 3, 3, 1, 0, 0);
         settle();
         check($sformatf("s4 stall c%0d", i), int'(stall), (i <= 10) ? 1 : 0);
         check($sformatf("s4 busy c%0d", i), int'(md_busy), (i <= 10) ? 1 : 0);
         adv();
      end
      idle();
      settle();
`ifdef HAZARD_STATS_EN
      check("s4 stall_cnt", int'(stall_cnt), 11);
`else
      check("s4 stall_cnt", int'(stall_cnt), 0);
`endif
      adv();

      // Reset with lw $7 in EX and a div running
      drive(1, 7, 2, 0, 0, 3, 3, 0, 1, 1);
      settle(); adv();
      do_reset();
      drive(0, 0, 0, 7, 0, 0, 3, 1, 0, 0);
      settle();
      check("s5 md_busy", int'(md_busy), 0);
      check("s5 fwd_sel", int'(id_fwd_sel), 0);
      check("s5 stall", int'(stall), 0);
      adv();

      // Random traffic with occasional reset
      for (int n = 0; n < 2000; n++) begin
         reset = ($urandom_range(0, 59) == 0);
         drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 2),
               $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1));
         settle();
         adv();
      end
      reset = 1'b0;
      idle();
      settle();
      adv();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
